// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: hazard and forwarding controller for the 5-stage RV32 pipeline.
//
// The unit has two parts:
// - Combinational logic for forwarding selects, store-data forwarding, load-use
//   stalls and branch flushes.
// - A small FSM that holds the front of the pipeline while a multi-cycle EX
//   operation (mul/div) occupies EX for MUL_LAT cycles.
//
// Parameters
//   AW       register-address width
//   MUL_LAT  EX-occupancy cycles of a multi-cycle op (2..16)
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   id_rs1/2, id_rs1/2_used          ID-stage sources and their use flags
//   ex_rs1/2, ex_rd                  EX-stage registers
//   ex_mem_read, ex_multicycle       EX holds a load / a multi-cycle op
//   branch_taken                     EX redirect
//   mem_rs2, mem_rd, mem_mem_write,  MEM-stage registers and controls
//   mem_reg_write
//   wb_rd, wb_reg_write              WB writeback
//   stall_pc, stall_ifid             hold PC and IF/ID
//   flush_ifid                       turn IF/ID into a NOP
//   hold_idex, bubble_idex           keep ID/EX / load NOP into ID/EX
//   bubble_exmem                     load NOP into EX/MEM
//   busa_fw, busb_fw                 operand select: 00 regfile, 10 MEM, 01 WB
//   di_src                           store data taken from the WB result
//   mc_busy, mc_done                 FSM busy / last EX cycle of the op
//   stall_cnt                        cycles with stall_pc high (only when the
//                                    HDU_PERF_CNT_EN macro is defined)
//
// All outputs are forced low while rst_n is low.

module hazard_ctrl_mc #(
  parameter int unsigned AW      = 5,
  parameter int unsigned MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [AW-1:0] ex_rs1,
  input  logic [AW-1:0] ex_rs2,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_mem_read,
  input  logic          ex_multicycle,
  input  logic          branch_taken,
  input  logic [AW-1:0] mem_rs2,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_mem_write,
  input  logic          mem_reg_write,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_reg_write,
  output logic          stall_pc,
  output logic          stall_ifid,
  output logic          flush_ifid,
  output logic          hold_idex,
  output logic          bubble_idex,
  output logic          bubble_exmem,
  output logic [1:0]    busa_fw,
  output logic [1:0]    busb_fw,
  output logic          di_src,
  output logic          mc_busy,
  output logic          mc_done
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  // Launch cycle plus the BUSY cycles that count down to zero make MUL_LAT cycles in total.
  localparam logic [CntW-1:0] CntLaunch = CntW'(MUL_LAT - 2);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            mc_busy_q;
  logic            mc_done_q;

  logic       mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic [1:0] fw_a, fw_b;
  logic       di_fw;
  logic       load_use;
  logic       launch, busy_hold, hold, idle_free, flush, lu_stall;

  // Forwarding and hazard detection (state independent except for the FSM gating).
  always_comb begin
    mem_hit_a = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1);
    mem_hit_b = mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2);
    wb_hit_a  = wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1);
    wb_hit_b  = wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2);

    // The MEM result is younger than the WB result, so MEM has priority.
    fw_a = mem_hit_a ? 2'b10 : (wb_hit_a ? 2'b01 : 2'b00);
    fw_b = mem_hit_b ? 2'b10 : (wb_hit_b ? 2'b01 : 2'b00);

    di_fw = wb_reg_write && (wb_rd != '0) && (wb_rd == mem_rs2) && mem_mem_write;

    load_use = ex_mem_read && (ex_rd != '0) &&
               ((id_rs1_used && (ex_rd == id_rs1)) || (id_rs2_used && (ex_rd == id_rs2)));

    // A branch that arrives together with a multi-cycle op wins; the launch is dropped.
    launch    = (state_q == StIdle) && ex_multicycle && !branch_taken;
    busy_hold = (state_q == StBusy) && (cnt_q != '0);
    hold      = launch || busy_hold;
    idle_free = (state_q == StIdle) && !launch;
    flush     = idle_free && branch_taken;
    // The wrong-path ID instruction is discarded on a flush, so its load-use hazard is moot.
    lu_stall  = idle_free && !branch_taken && load_use;
  end

  always_comb begin
    stall_pc     = rst_n && (hold || lu_stall);
    stall_ifid   = rst_n && (hold || lu_stall);
    flush_ifid   = rst_n && flush;
    hold_idex    = rst_n && hold;
    bubble_idex  = rst_n && (flush || lu_stall);
    bubble_exmem = rst_n && hold;
    busa_fw      = rst_n ? fw_a : 2'b00;
    busb_fw      = rst_n ? fw_b : 2'b00;
    di_src       = rst_n && di_fw;
    mc_busy      = rst_n && mc_busy_q;
    mc_done      = rst_n && mc_done_q;
  end

  // Multi-cycle FSM. mc_busy_q and mc_done_q are kept registered alongside the state.
  // mc_done_q is high exactly when the FSM is in BUSY with the counter at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mc_busy_q <= 1'b0;
      mc_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ex_multicycle && !branch_taken) begin
            state_q   <= StBusy;
            cnt_q     <= CntLaunch;
            mc_busy_q <= 1'b1;
            mc_done_q <= (CntLaunch == '0);
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q     <= cnt_q - CntW'(1);
            mc_done_q <= (cnt_q == CntW'(1));
          end else begin
            // The op leaves EX at this edge. A following op may launch in the next cycle.
            state_q   <= StIdle;
            mc_busy_q <= 1'b0;
            mc_done_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          mc_busy_q <= 1'b0;
          mc_done_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HDU_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // The counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_pc && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Testbench for hazard_ctrl_mc.
// Directed cases plus randomized traffic, checked against a cycle-level reference model
// that tracks the remaining EX occupancy of a multi-cycle op.
module tb_hazard_ctrl_mc;

  localparam int unsigned AW      = 5;
  localparam int unsigned MUL_LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rs2, mem_rd, wb_rd;
  logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_multicycle, branch_taken;
  logic          mem_mem_write, mem_reg_write, wb_reg_write;
  logic          stall_pc, stall_ifid, flush_ifid, hold_idex, bubble_idex, bubble_exmem;
  logic [1:0]    busa_fw, busb_fw;
  logic          di_src, mc_busy, mc_done;
`ifdef HDU_PERF_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  hazard_ctrl_mc #(
    .AW      (AW),
    .MUL_LAT (MUL_LAT)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_read   (ex_mem_read),
    .ex_multicycle (ex_multicycle),
    .branch_taken  (branch_taken),
    .mem_rs2       (mem_rs2),
    .mem_rd        (mem_rd),
    .mem_mem_write (mem_mem_write),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .stall_pc      (stall_pc),
    .stall_ifid    (stall_ifid),
    .flush_ifid    (flush_ifid),
    .hold_idex     (hold_idex),
    .bubble_idex   (bubble_idex),
    .bubble_exmem  (bubble_exmem),
    .busa_fw       (busa_fw),
    .busb_fw       (busb_fw),
    .di_src        (di_src),
    .mc_busy       (mc_busy),
    .mc_done       (mc_done)
`ifdef HDU_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [12:0] got_ctrl;
  assign got_ctrl = {stall_pc, stall_ifid, flush_ifid, hold_idex, bubble_idex, bubble_exmem,
                     busa_fw, busb_fw, di_src, mc_busy, mc_done};

  int          n_total = 0;
  int          n_bad   = 0;
  int          rem     = 0;  // BUSY cycles still to come for the op in EX
  int          model_cnt = 0;
  logic [12:0] exp_ctrl;
  logic        exp_stall;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ref_fw(input logic [AW-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    rst_n = 1'b1;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0;
    ex_multicycle = 1'b0; branch_taken = 1'b0;
    mem_rs2 = '0; mem_rd = '0; mem_mem_write = 1'b0; mem_reg_write = 1'b0;
    wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  // Inputs are set at the negedge; the outputs are compared 1 time unit later.
  task automatic eval_cycle(input string tag);
    logic s, f, h, bi, di, busy, done, lu;
    logic [1:0] fa, fb;
    #1;
    s = 0; f = 0; h = 0; bi = 0; di = 0; busy = 0; done = 0; fa = 0; fb = 0;
    if (rst_n) begin
      fa = ref_fw(ex_rs1);
      fb = ref_fw(ex_rs2);
      di = wb_reg_write && wb_rd != 0 && wb_rd == mem_rs2 && mem_mem_write;
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_rs1_used && ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2));
      if (rem > 0) begin
        busy = 1; done = (rem == 1); h = (rem > 1); s = h;
      end else if (ex_multicycle && !branch_taken) begin
        h = 1; s = 1;
      end else if (branch_taken) begin
        f = 1; bi = 1;
      end else if (lu) begin
        s = 1; bi = 1;
      end
    end
    exp_stall = s;
    exp_ctrl  = {s, s, f, h, bi, h, fa, fb, di, busy, done};
    check_eq(tag, 32'(got_ctrl), 32'(exp_ctrl));
`ifdef HDU_PERF_CNT_EN
    check_eq({tag, "_stall_cnt"}, stall_cnt, model_cnt);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      rem = 0;
      model_cnt = 0;
    end else begin
      if (rem > 0) rem--;
      else if (ex_multicycle && !branch_taken) rem = MUL_LAT - 1;
      if (exp_stall) model_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    // While reset is low, hazard-provoking inputs must still give all-zero outputs.
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1'b1; ex_multicycle = 1'b1;
    eval_cycle("reset0");
    check_eq("reset_ctrl", 32'(got_ctrl), 32'd0);
    advance();
    eval_cycle("reset1");
    advance();
    clear_inputs();

    // Forward priority: MEM beats WB, and register 0 never forwards.
    ex_rs1 = 5; mem_rd = 5; wb_rd = 5; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    eval_cycle("fw_mem");
    check_eq("busa_mem", 32'(busa_fw), 32'd2);
    advance();
    mem_rd = 0;
    eval_cycle("fw_wb");
    check_eq("busa_wb", 32'(busa_fw), 32'd1);
    advance();
    wb_rd = 0;
    eval_cycle("fw_none");
    check_eq("busa_none", 32'(busa_fw), 32'd0);
    advance();
    clear_inputs();
    mem_rs2 = 9; wb_rd = 9; wb_reg_write = 1'b1; mem_mem_write = 1'b1;
    eval_cycle("di_src");
    check_eq("di_src_hit", 32'(di_src), 32'd1);
    advance();
    clear_inputs();

    // Three load-use stalls; each bubble clears the condition in the next cycle.
    for (int i = 0; i < 3; i++) begin
      ex_mem_read = 1'b1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1'b1;
      eval_cycle("lu_stall");
      check_eq("lu_stall_pc", 32'(stall_pc), 32'd1);
      check_eq("lu_bubble", 32'(bubble_idex), 32'd1);
      advance();
      clear_inputs();
      eval_cycle("lu_clear");
      check_eq("lu_clear_pc", 32'(stall_pc), 32'd0);
      advance();
    end
    ex_mem_read = 1'b1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1'b0;
    eval_cycle("lu_unused");
    check_eq("lu_unused_pc", 32'(stall_pc), 32'd0);
    advance();
    clear_inputs();

    // Multi-cycle op with MUL_LAT=4 held in EX for cycles 0..3.
    for (int c = 0; c < 5; c++) begin
      ex_multicycle = (c < 4);
      eval_cycle("mc_seq");
      check_eq("mc_hold", 32'(hold_idex), 32'(c < 3));
      check_eq("mc_busy", 32'(mc_busy), 32'(c >= 1 && c <= 3));
      check_eq("mc_done", 32'(mc_done), 32'(c == 3));
      advance();
    end
`ifdef HDU_PERF_CNT_EN
    check_eq("perf_cnt6", stall_cnt, 32'd6);
`endif
    clear_inputs();

    // A branch suppresses the load-use stall.
    ex_mem_read = 1'b1; ex_rd = 7; id_rs2 = 7; id_rs2_used = 1'b1; branch_taken = 1'b1;
    eval_cycle("br_lu");
    check_eq("br_flush", 32'(flush_ifid), 32'd1);
    check_eq("br_stall", 32'(stall_pc), 32'd0);
    advance();
    clear_inputs();

    // A multi-cycle op together with a branch: the branch wins and no op launches.
    ex_multicycle = 1'b1; branch_taken = 1'b1;
    eval_cycle("br_mc");
    check_eq("br_mc_hold", 32'(hold_idex), 32'd0);
    advance();
    clear_inputs();
    eval_cycle("br_mc_after");
    check_eq("br_mc_busy", 32'(mc_busy), 32'd0);
    advance();

    // Reset asserted in cycle 2 of an op: the op is abandoned.
    for (int c = 0; c < 4; c++) begin
      ex_multicycle = (c < 3);
      rst_n = (c != 2);
      if (c == 3) ex_multicycle = 1'b0;
      eval_cycle("rst_busy");
      if (c == 2) check_eq("rst_busy_ctrl", 32'(got_ctrl), 32'd0);
      if (c == 3) check_eq("rst_no_done", 32'(mc_done), 32'd0);
      advance();
    end
    clear_inputs();

    // Randomized traffic, including back-to-back multi-cycle ops.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
      ex_rd  = AW'($urandom_range(0, 3)); mem_rs2 = AW'($urandom_range(0, 3));
      mem_rd = AW'($urandom_range(0, 3)); wb_rd = AW'($urandom_range(0, 3));
      id_rs1_used   = 1'($urandom_range(0, 1));
      id_rs2_used   = 1'($urandom_range(0, 1));
      ex_mem_read   = 1'($urandom_range(0, 1));
      mem_mem_write = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      ex_multicycle = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      eval_cycle("rand");
      advance();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
